// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache with 4-word burst refill over a valid-handshake memory port.
module instruction_cache #(
  parameter int LINES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        invalidate,
  output logic        hit,
  output logic [31:0] instruction,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;
  typedef enum logic {IDLE, REFILL} state_t;
  state_t          r_state;
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]   r_tag [LINES];
  logic [31:0]     r_data [LINES][4];
  logic [1:0]      r_cnt;
  logic            r_discard;
  logic [IW-1:0]   w_idx, w_fidx;
  logic [TW-1:0]   w_tag, w_ftag;
  logic            w_hit;
  logic            w_unused;
  assign w_idx  = pc[4+IW-1:4];
  assign w_tag  = pc[31:4+IW];
  assign w_fidx = mem_addr[4+IW-1:4];
  assign w_ftag = mem_addr[31:4+IW];
  assign w_unused = ^{pc[1:0], mem_addr[3:0]};
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && (r_state == IDLE);
  assign hit = w_hit;
  assign instruction = w_hit ? r_data[w_idx][pc[3:2]] : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_cnt     <= '0;
      r_discard <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else if (r_state == IDLE) begin
      if (invalidate) r_valid <= '0;
      if (!w_hit) begin
        mem_addr       <= {pc[31:4], 4'b0};
        r_cnt          <= '0;
        r_state        <= REFILL;
        mem_req        <= 1'b1;
        r_valid[w_idx] <= 1'b0;
      end
    end else begin
      if (invalidate) begin
        r_valid   <= '0;
        r_discard <= 1'b1;
      end
      if (mem_valid) begin
        r_cnt <= r_cnt + 2'd1;
        // an invalidate landing on the final edge must also leave the line invalid
        if (r_cnt == 2'd3) begin
          r_valid[w_fidx] <= !(r_discard || invalidate);
          r_discard       <= 1'b0;
          r_state         <= IDLE;
          mem_req         <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && r_state == REFILL && mem_valid) begin
      r_data[w_fidx][r_cnt] <= mem_rdata;
      if (r_cnt == 2'd3) r_tag[w_fidx] <= w_ftag;
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed test-plan scenarios plus randomized traffic checked against a line-level cache model.
module tb_instruction_cache;
  localparam int LINES = 16;
  localparam int IW = $clog2(LINES);
  logic        clock = 0, reset = 1, invalidate = 0, mem_valid = 0;
  logic [31:0] pc = 0, mem_rdata = 0;
  logic        hit, mem_req;
  logic [31:0] instruction, mem_addr;
  int total = 0, bad = 0;
  bit          m_valid [LINES];
  int unsigned m_tag [LINES];
  logic [31:0] m_data [LINES][4];
  bit          m_busy = 0, m_disc = 0;
  int          m_cnt = 0, gap = 0, wait_mode = 0, n;
  logic [31:0] m_base = 0;
  bit          force_valid = 0;

  instruction_cache #(.LINES(LINES)) dut (
    .clock(clock), .reset(reset), .pc(pc), .invalidate(invalidate),
    .hit(hit), .instruction(instruction), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 4) % LINES;
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] a);
    return a >> (4 + IW);
  endfunction
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a < 32'h100) ? 32'(32'h11 * (((a >> 2) & 3) + 1)) : (a ^ 32'hA5A5_5A5A);
  endfunction
  function automatic bit exp_hit();
    return !m_busy && m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction
  function automatic logic [31:0] exp_ins();
    return exp_hit() ? m_data[idx_of(pc)][(pc >> 2) % 4] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t pc=%h)", tag, got, exp, $time, pc);
    end
  endtask

  task automatic drive();
    bit v;
    if (m_busy) begin
      v = (wait_mode == 0) ? 1'b1 : (wait_mode == 1) ? (gap == 2) : ($urandom % 3 != 0);
      gap = v ? 0 : gap + 1;
      mem_valid = v;
      mem_rdata = memword(m_base + 32'(m_cnt * 4));
    end else begin
      mem_valid = force_valid || (wait_mode == 2 && $urandom % 8 == 0);
      mem_rdata = force_valid ? 32'hDEAD_BEEF : $urandom;
    end
  endtask

  task automatic model_update();
    bit h;
    if (reset) begin
      m_busy = 0; m_disc = 0; m_base = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else if (!m_busy) begin
      h = exp_hit();
      if (invalidate) foreach (m_valid[i]) m_valid[i] = 0;
      if (!h) begin
        m_busy = 1; m_base = pc & ~32'hF; m_cnt = 0; gap = 2;
        m_valid[idx_of(pc)] = 0;
      end
    end else begin
      if (invalidate) begin
        foreach (m_valid[i]) m_valid[i] = 0;
        m_disc = 1;
      end
      if (mem_valid) begin
        m_data[idx_of(m_base)][m_cnt] = mem_rdata;
        m_cnt++;
        if (m_cnt == 4) begin
          m_tag[idx_of(m_base)] = tag_of(m_base);
          m_valid[idx_of(m_base)] = !m_disc;
          m_disc = 0; m_busy = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    drive();
    #1;
    chk("hit", hit, exp_hit());
    chk("ins", instruction, exp_ins());
    chk("req", mem_req, m_busy);
    chk("addr", mem_addr, m_base);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic run_until_hit(input int budget, output int cnt);
    cnt = 0;
    forever begin
      #1;
      if (hit || cnt >= budget) break;
      cyc();
      cnt++;
    end
  endtask

  task automatic finish_refill();
    for (int k = 0; k < 100 && m_busy; k++) cyc();
  endtask

  initial begin
    @(posedge clock);
    model_update();
    @(negedge clock);
    cyc();
    chk("rst_req", mem_req, 0);
    chk("rst_hit", hit, 0);
    reset = 0;
    // cold miss with zero-wait memory
    wait_mode = 0; pc = 32'h40;
    run_until_hit(20, n);
    chk("cold_lat", n, 5);
    chk("cold_addr", mem_addr, 32'h40);
    chk("cold_ins", instruction, 32'h11);
    pc = 32'h4C; #1;
    chk("word3_hit", hit, 1);
    chk("word3_ins", instruction, 32'h44);
    // conflict eviction
    pc = 32'h140;
    run_until_hit(20, n);
    chk("evict_addr", mem_addr, 32'h140);
    pc = 32'h40; #1;
    chk("evict_miss", hit, 0);
    run_until_hit(20, n);
    chk("refill3_lat", n, 5);
    chk("refill3_addr", mem_addr, 32'h40);
    // two idle cycles between every data beat
    wait_mode = 1; pc = 32'h1000;
    run_until_hit(40, n);
    chk("gap_lat", n, 11);
    // pc moves during the burst
    wait_mode = 2; pc = 32'h2000;
    cyc(); cyc(); cyc();
    pc = 32'h3040;
    finish_refill();
    chk("pcchg_idle", mem_req, 0);
    cyc();
    chk("pcchg_req", mem_req, 1);
    chk("pcchg_addr", mem_addr, 32'h3040);
    run_until_hit(100, n);
    pc = 32'h2000; #1;
    chk("orig_hit", hit, 1);
    chk("orig_ins", instruction, memword(32'h2000));
    // invalidate while idle
    invalidate = 1; cyc(); invalidate = 0; #1;
    chk("inv_a", hit, 0);
    pc = 32'h3040; #1;
    chk("inv_b", hit, 0);
    // invalidate in the middle of a burst
    wait_mode = 0; pc = 32'h5000;
    cyc(); cyc();
    invalidate = 1; cyc(); invalidate = 0;
    finish_refill();
    #1;
    chk("invb_hit", hit, 0);
    cyc();
    chk("invb_req", mem_req, 1);
    chk("invb_addr", mem_addr, 32'h5000);
    run_until_hit(20, n);
    chk("invb_lat", n, 4);
    // reset abandons a refill; stray beats are ignored
    pc = 32'h6000;
    cyc(); cyc(); cyc();
    reset = 1; cyc();
    chk("rstm_req", mem_req, 0);
    chk("rstm_hit", hit, 0);
    force_valid = 1; cyc(); cyc(); force_valid = 0;
    chk("stray_req", mem_req, 0);
    reset = 0; pc = 32'h5000; #1;
    chk("stray_nohit", hit, 0);
    pc = 32'h6000;
    run_until_hit(20, n);
    chk("rstm_lat", n, 5);
    chk("rstm_ins", instruction, memword(32'h6000));
    // randomized traffic
    wait_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 3 == 0)
        pc = (($urandom % 4) << (4 + IW)) | (($urandom % LINES) << 4) | ($urandom % 16);
      invalidate = ($urandom % 40 == 0);
      reset = ($urandom % 300 == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the 32-bit program counter and main memory. Each cycle it looks up the current PC and drives the instruction word plus a `hit` flag that the program counter and control unit use to stall fetch. On a miss it runs a 4-word burst refill through a valid-handshake memory port, then installs the line.

## Interface

- `LINES`, 16: number of cache lines. Must be a power of two, 2 to 256.
- `clock`, in, 1: system clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `pc`, in, 32: fetch address from the program counter.
- `invalidate`, in, 1: one-cycle pulse that flushes all lines.
- `hit`, out, 1: `instruction` is valid for the current `pc`.
- `instruction`, out, 32: cached word when `hit` is 1; `32'h0000_0000` (nop) otherwise.
- `mem_req`, out, 1: refill request, held high for the whole burst.
- `mem_addr`, out, 32: line-aligned burst base address.
- `mem_rdata`, in, 32: burst data word.
- `mem_valid`, in, 1: `mem_rdata` is valid this cycle.

## Operation

**Address split** (`IW = log2(LINES)`):
- `pc[1:0]` is ignored.
- Word offset is `pc[3:2]`.
- Index is `pc[4+IW-1:4]`.
- Tag is `pc[31:4+IW]`.

**Storage:**
- Per line: valid bit, tag, and 4 data words.
- All storage is registers; no RAM macro.

**Lookup (combinational):**
- `hit = valid[index] & (tag[index] == pc tag) & (state == IDLE)`.
- `instruction` is the selected word when `hit` is 1, else zero.

**FSM, two states:**
- IDLE:
  - If `!hit` and not `reset`, latch `{pc[31:4], 4'b0}` into `mem_addr`, clear the word counter, go to REFILL.
  - A pending `invalidate` in the same cycle is applied first.
- REFILL:
  - `mem_req` = 1.
  - On each rising edge with `mem_valid` = 1, write `mem_rdata` into word[counter] of the line at the latched index, then increment the counter (2 bits).
  - On the edge that captures word 3: write the latched tag, set `valid` unless the discard flag is set, clear the discard flag, go to IDLE.
  - `mem_req` falls on that same edge.

**Boundary rules:**
- **`pc` changes during REFILL:** the burst completes to the latched address and is not restarted. Lookup resumes on return to IDLE, and a new miss starts a new refill the following cycle.
- **`invalidate` in IDLE:** all valid bits clear on that edge.
- **`invalidate` in REFILL:** all valid bits clear and the discard flag sets, so the line in flight is written but left invalid.
- **`mem_valid` outside REFILL:** ignored.
- **Memory data order:** burst words arrive in order 0..3. `mem_valid` may be high for consecutive cycles, or with gaps.
- **Refill over a valid line:** overwrites it. The line's valid bit is cleared at refill start, so a partially written line is never reported as a hit.
- **`reset` mid-refill:** abandons the burst. `mem_req` drops on the reset edge. Late `mem_valid` pulses are ignored.

## Timing

- **Reset values:**
  - state IDLE; all valid bits 0; counter 0; discard flag 0.
  - `mem_req` 0, `mem_addr` 0.
  - `hit` 0 and `instruction` 0, because no line is valid.
  - Tags and data are not reset.
- **Hit latency:** zero cycles; `hit` and `instruction` are combinational from `pc`. The program counter samples on the falling edge, so the lookup path must settle within half a cycle.
- **Miss timing:**
  - Miss seen in cycle 0.
  - `mem_req` is high from cycle 1.
  - With zero-wait memory (`mem_valid` high in cycles 1–4), `hit` rises in cycle 5. The minimum miss penalty is 5 cycles.
  - Each memory wait cycle adds one cycle.
- **During REFILL:** `hit` is 0 throughout, including when `pc` maps to another valid line.

## Test plan

- **Cold miss, then hit.** After reset, `pc=0x0000_0040`; memory returns `0x11,0x22,0x33,0x44` with zero wait.
  - Required: `mem_addr=0x40`, `mem_req` high for cycles 1–4, `hit=1`, `instruction=0x11` in cycle 5.
  - Then `pc=0x4C` gives `instruction=0x44` with `hit=1` immediately.
- **Conflict eviction.**
  - Fill `pc=0x040`, then `pc=0x140` (same index, different tag). Required: a second refill with `mem_addr=0x140`.
  - Return to `0x040`. Required: a miss and a third refill.
- **Wait states and PC change.**
  - Gaps of 2 idle cycles between `mem_valid` pulses. Required: refill lasts 4 + 6 cycles.
  - Change `pc` mid-burst to an unrelated address. Required: the original line is installed, then a new refill starts for the new `pc`.
- **Invalidate.**
  - `invalidate` in IDLE after two lines are filled. Required: both miss afterwards.
  - `invalidate` during a burst. Required: the line is not valid afterwards and the same `pc` re-misses.
- **Reset mid-refill.** Assert `reset` after 2 words, then send 2 stray `mem_valid` pulses. Required: `mem_req=0`, `hit=0`, no line valid, stray data ignored.
